// File: rtl/seq_detector_param_if.sv
// Serial detector bus: sample stream, runtime configuration and match counter.
// The master side feeds bits and configuration; the slave side is the detector.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
);
  logic               in_valid;
  logic               in;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               out;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;

  modport master (
    output in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  out, match_count, count_sat
  );

  modport slave (
    input  in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output out, match_count, count_sat
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable Moore bit-sequence detector with a saturating match counter.
// The pattern is right-aligned: bit [len-1] is the oldest bit, bit [0] the newest.
module seq_detector_param #(
  parameter int                 MAX_LEN         = 8,
  parameter int                 LEN_W           = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W           = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_0110,
  parameter int                 DEFAULT_LEN     = 4,
  parameter logic               DEFAULT_OVERLAP = 1'b0
) (
  input logic                  clk,
  input logic                  reset_n,
  seq_detector_param_if.slave  bus
);

  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               out_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sat_q;

  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] new_hist;
  logic [LEN_W-1:0]   new_fill;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;
  logic               sample_hit;

  // Next-history candidate and match test against the clamped pattern length
  always_comb begin
    eff_len  = (len_q > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_q;
    new_hist = {history[MAX_LEN-2:0], bus.in};
    new_fill = (fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill + 1'b1;
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(eff_len));
    end
    hit        = (eff_len != '0) && (new_fill >= eff_len) &&
                 (((new_hist ^ pat_q) & len_mask) == '0);
    sample_hit = bus.in_valid && !bus.cfg_load && hit;
  end

  // Configuration, history, match pulse and counter; cfg_load wins over sampling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      history <= '0;
      fill    <= '0;
      pat_q   <= DEFAULT_PATTERN;
      len_q   <= LEN_W'(DEFAULT_LEN);
      ovl_q   <= DEFAULT_OVERLAP;
      out_q   <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      if (bus.cfg_load) begin
        pat_q   <= bus.cfg_pattern;
        len_q   <= bus.cfg_len;
        ovl_q   <= bus.cfg_overlap;
        history <= '0;
        fill    <= '0;
        out_q   <= 1'b0;
      end else if (bus.in_valid) begin
        out_q <= hit;
        if (hit && !ovl_q) begin
          history <= '0;
          fill    <= '0;
        end else begin
          history <= new_hist;
          fill    <= new_fill;
        end
      end else begin
        out_q <= 1'b0;
      end

      if (bus.cnt_clr) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (sample_hit) begin
        if (cnt_q == '1) begin
          sat_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.out         = out_q;
  assign bus.match_count = cnt_q;
  assign bus.count_sat   = sat_q;

endmodule
